// File: rtl/axi4_lite_ram_pkg.sv
// Shared types for the AXI4-Lite scratch RAM.
// Response codes and the two channel state machines.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_t;

  function automatic logic [15:0] sat_add16(
    input logic [15:0] a,
    input logic [1:0]  inc
  );
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/axi4_lite_ram_array.sv
// Word storage with byte-lane writes and one registered read port.
// Only word 0 is touched by reset; the rest keep their contents.
module axi4_lite_ram_array #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH       = 64,
  parameter logic [31:0] RESET_WORD0 = 32'hDEADBEEF,
  localparam int         STRBW       = DATA_WIDTH / 8,
  localparam int         IDXW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [STRBW-1:0]      wr_be,
  input  logic [IDXW-1:0]       wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  rd_zero,
  input  logic                  rd_clr,
  input  logic [IDXW-1:0]       rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] word0_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] rd_d;
  logic [DATA_WIDTH-1:0] rd_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word0_q <= DATA_WIDTH'(RESET_WORD0);
    end else if (wr_idx == '0) begin
      for (int b = 0; b < STRBW; b++) begin
        if (wr_be[b]) word0_q[b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Word 0 lives in its own register so the bulk array needs no reset.
  always_ff @(posedge clk) begin
    if (wr_idx != '0) begin
      for (int b = 0; b < STRBW; b++) begin
        if (wr_be[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  assign rd_word = (rd_idx == '0) ? word0_q : mem[rd_idx];

  always_comb begin
    rd_d = rd_q;
    if (rd_en) begin
      rd_d = rd_zero ? '0 : rd_word;
    end else if (rd_clr) begin
      rd_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_q <= '0;
    else       rd_q <= rd_d;
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/axi4_lite_ram.sv
// AXI4-Lite slave RAM: decoupled AW/W capture, held B/R responses,
// out-of-range SLVERR and a saturating error counter.
module axi4_lite_ram
  import axi4_lite_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH       = 64,
  parameter logic [31:0] RESET_WORD0 = 32'hDEADBEEF,
  localparam int         STRBW       = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRBW-1:0]      wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [15:0]           err_count
);

  localparam int OFS  = $clog2(STRBW);
  localparam int IDXW = $clog2(DEPTH);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (OFS + IDXW)) == '0;
  endfunction

  wr_state_t w_state_q, w_state_d;
  rd_state_t r_state_q, r_state_d;

  logic                  rdy_q;
  logic                  aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRBW-1:0]      wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  resp_t                 bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  resp_t                 rresp_q, rresp_d;
  logic [15:0]           err_q, err_d;

  logic                  aw_fire, w_fire, ar_fire;
  logic [ADDR_WIDTH-1:0] wr_addr_sel;
  logic [DATA_WIDTH-1:0] wr_data_sel;
  logic [STRBW-1:0]      wr_strb_sel;
  logic [STRBW-1:0]      mem_we;
  logic                  wr_err, rd_err;
  logic                  rd_en, rd_zero, rd_clr;

  // Readies come only from registers; rdy_q keeps them low through reset.
  assign awready = rdy_q && (w_state_q == W_IDLE) && !aw_held_q;
  assign wready  = rdy_q && (w_state_q == W_IDLE) && !w_held_q;
  assign arready = rdy_q && (r_state_q == R_IDLE);

  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign ar_fire = arvalid && arready;

  assign wr_addr_sel = aw_held_q ? awaddr_q : awaddr;
  assign wr_data_sel = w_held_q  ? wdata_q  : wdata;
  assign wr_strb_sel = w_held_q  ? wstrb_q  : wstrb;

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    mem_we    = '0;
    wr_err    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
          if (in_range(wr_addr_sel)) begin
            mem_we  = wr_strb_sel;
            bresp_d = RESP_OKAY;
          end else begin
            bresp_d = RESP_SLVERR;
            wr_err  = 1'b1;
          end
          bvalid_d  = 1'b1;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_RESP;
        end else begin
          if (aw_fire) begin
            aw_held_d = 1'b1;
            awaddr_d  = awaddr;
          end
          if (w_fire) begin
            w_held_d = 1'b1;
            wdata_d  = wdata;
            wstrb_d  = wstrb;
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rd_en     = 1'b0;
    rd_zero   = 1'b0;
    rd_clr    = 1'b0;
    rd_err    = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_fire) begin
          rd_en     = 1'b1;
          rd_zero   = !in_range(araddr);
          rd_err    = rd_zero;
          rresp_d   = rd_zero ? RESP_SLVERR : RESP_OKAY;
          rvalid_d  = 1'b1;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (rready) begin
          rvalid_d  = 1'b0;
          rd_clr    = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    err_d = sat_add16(err_q, {1'b0, wr_err} + {1'b0, rd_err});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_q     <= 1'b0;
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      err_q     <= '0;
    end else begin
      rdy_q     <= 1'b1;
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      err_q     <= err_d;
    end
  end

  axi4_lite_ram_array #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH       (DEPTH),
    .RESET_WORD0 (RESET_WORD0)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .wr_be   (mem_we),
    .wr_idx  (wr_addr_sel[OFS +: IDXW]),
    .wr_data (wr_data_sel),
    .rd_en   (rd_en),
    .rd_zero (rd_zero),
    .rd_clr  (rd_clr),
    .rd_idx  (araddr[OFS +: IDXW]),
    .rd_data (rdata)
  );

  assign bvalid    = bvalid_q;
  assign bresp     = bresp_q;
  assign rvalid    = rvalid_q;
  assign rresp     = rresp_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_axi4_lite_ram.sv
// Bench for axi4_lite_ram: directed and random traffic against
// a word-array reference model.
module tb_axi4_lite_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;
  logic [15:0] err_count;

  int          vecs = 0;
  int          miss = 0;
  int          exp_err = 0;
  logic [31:0] model [64];

  axi4_lite_ram dut (
    .clk       (clk),
    .reset     (reset),
    .awaddr    (awaddr),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wvalid    (wvalid),
    .wready    (wready),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready),
    .araddr    (araddr),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rvalid    (rvalid),
    .rready    (rready),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic in_rng(input logic [31:0] a);
    return a < 32'h100;
  endfunction

  function automatic logic [31:0] rd_exp(input logic [31:0] a);
    return in_rng(a) ? model[a[7:2]] : 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, d,
                             input logic [3:0] s);
    if (in_rng(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model[a[7:2]][b*8 +: 8] = d[b*8 +: 8];
      end
    end
  endtask

  task automatic do_write(input logic [31:0] a, d, input logic [3:0] s,
                          input int daw, dw, hold);
    logic       awd, wd;
    logic [1:0] er;
    int         c;
    awd = 1'b0; wd = 1'b0; c = 0;
    while (!(awd && wd) && c < 60) begin
      @(negedge clk);
      awaddr  = a; wdata = d; wstrb = s;
      awvalid = !awd && (c >= daw);
      wvalid  = !wd && (c >= dw);
      if (awvalid && awready) awd = 1'b1;
      if (wvalid && wready) wd = 1'b1;
      c++;
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    er = in_rng(a) ? 2'b00 : 2'b10;
    chk("wr_accept", {30'd0, awd, wd}, 32'd3);
    chk("bvalid", bvalid, 1);
    chk("bresp", bresp, er);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bvalid_hold", bvalid, 1);
      chk("bresp_hold", bresp, er);
      chk("awready_hold", awready, 0);
      chk("wready_hold", wready, 0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("bvalid_clr", bvalid, 0);
    model_write(a, d, s);
    if (er != 2'b00) exp_err++;
    chk("err_count_w", err_count, exp_err);
  endtask

  task automatic do_read(input logic [31:0] a, input int hold);
    logic [31:0] ex;
    logic [1:0]  er;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    chk("arready", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    ex = rd_exp(a);
    er = in_rng(a) ? 2'b00 : 2'b10;
    if (er != 2'b00) exp_err++;
    chk("rvalid", rvalid, 1);
    chk("rdata", rdata, ex);
    chk("rresp", rresp, er);
    chk("err_count_r", err_count, exp_err);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rvalid_hold", rvalid, 1);
      chk("rdata_hold", rdata, ex);
      chk("arready_hold", arready, 0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("rvalid_clr", rvalid, 0);
    chk("rdata_clr", rdata, 0);
  endtask

  initial begin
    logic [31:0] a, d, old;
    reset = 1'b1;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    repeat (2) @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err_count, 0);
    reset = 1'b0;
    model[0] = 32'hDEADBEEF;
    @(negedge clk);
    chk("post_awready", awready, 1);
    chk("post_wready", wready, 1);
    chk("post_arready", arready, 1);

    do_read(32'h0, 0);

    for (int i = 1; i < 64; i++) begin
      do_write(i * 4, $urandom, 4'hF, $urandom_range(0, 2),
               $urandom_range(0, 2), 0);
    end

    do_write(32'h10, 32'h12345678, 4'hF, 2, 5, 0);
    do_read(32'h10, 0);
    do_write(32'h10, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
    do_read(32'h10, 0);
    chk("strb_merge", model[4], 32'h12BB56DD);
    do_write(32'h100, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_read(32'h100, 0);
    chk("err_two", err_count, 32'd2);
    do_read(32'h10, 0);
    do_write(32'h18, 32'h0BADF00D, 4'h0, 1, 0, 0);
    do_read(32'h18, 0);

    do_write(32'h20, $urandom, 4'hF, 0, 0, 10);
    do_read(32'h20, 10);

    for (int i = 0; i < 40; i++) begin
      a = $urandom & 32'hFF;
      if ($urandom_range(0, 3) == 0) a = a | (32'h1 << $urandom_range(8, 31));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3));
      else
        do_read(a, $urandom_range(0, 3));
    end

    old = model[5];
    d = $urandom;
    @(negedge clk);
    awaddr = 32'h14; wdata = d; wstrb = 4'hF; araddr = 32'h14;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("rw_same_rdata", rdata, old);
    chk("rw_same_bvalid", bvalid, 1);
    bready = 1; rready = 1;
    @(negedge clk);
    bready = 0; rready = 0;
    model[5] = d;
    do_read(32'h14, 0);

    @(negedge clk);
    araddr = 32'h10; arvalid = 1; awaddr = 32'h20; awvalid = 1;
    @(negedge clk);
    arvalid = 0; awvalid = 0;
    chk("mid_rvalid", rvalid, 1);
    chk("mid_aw_held", awready, 0);
    #2 reset = 1'b1;
    #1;
    chk("ar_rvalid", rvalid, 0);
    chk("ar_rdata", rdata, 0);
    chk("ar_awready", awready, 0);
    chk("ar_arready", arready, 0);
    chk("ar_bvalid", bvalid, 0);
    chk("ar_err", err_count, 0);
    exp_err = 0;
    model[0] = 32'hDEADBEEF;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_awready", awready, 1);
    chk("rel_wready", wready, 1);
    d = $urandom;
    wdata = d; wstrb = 4'hF; wvalid = 1;
    @(negedge clk);
    wvalid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("w_alone_bvalid", bvalid, 0);
      chk("w_alone_wready", wready, 0);
    end
    awaddr = 32'h24; awvalid = 1;
    @(negedge clk);
    awvalid = 0;
    chk("late_aw_bvalid", bvalid, 1);
    chk("late_aw_bresp", bresp, 0);
    bready = 1;
    @(negedge clk);
    bready = 0;
    model[9] = d;
    do_read(32'h24, 0);
    do_read(32'h20, 0);
    do_read(32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/axi4_lite_ram.md
# axi4_lite_ram

Parametrised AXI4-Lite slave RAM, the next-generation register/scratch memory for bus-attached debug and control storage. Adds configurable width and depth, byte-strobe writes, decoupled AW/W capture, held B/R responses with full backpressure, out-of-range error responses and a saturating error counter. Sits behind the system AXI4-Lite interconnect as a leaf slave.

## Interface
- ADDR_WIDTH, 32: AXI byte-address width.
- DATA_WIDTH, 32: data width; 32 or 64 only.
- DEPTH, 64: number of words; power of two, ≥ 2.
- RESET_WORD0, 32'hDEADBEEF: value loaded into word 0 on reset, zero-extended to DATA_WIDTH.
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- awaddr  in  ADDR_WIDTH; awvalid in 1; awready out 1.
- wdata  in  DATA_WIDTH; wstrb in DATA_WIDTH/8; wvalid in 1; wready out 1.
- bresp  out  2; bvalid out 1; bready in 1.
- araddr  in  ADDR_WIDTH; arvalid in 1; arready out 1.
- rdata  out  DATA_WIDTH; rresp out 2; rvalid out 1; rready in 1.
- err_count  out  16  saturating count of SLVERR responses (read + write).
- AWPROT/ARPROT are not ported; protection is ignored.

## Operation
- Word index = addr[OFS +: IDXW], OFS = log2(DATA_WIDTH/8), IDXW = log2(DEPTH). Low OFS bits ignored.
- Out of range: any addr bit at or above OFS+IDXW set -> SLVERR (2'b10), no write, rdata = 0. Otherwise OKAY (2'b00).
- Write FSM, states W_IDLE, W_RESP:
  - W_IDLE: awready = !aw_held, wready = !w_held. AW and W are captured independently into holding registers, in either order or together.
  - At the edge where both are held or firing: byte lanes with wstrb=1 written, bresp set, bvalid <= 1, holds cleared, -> W_RESP.
  - W_RESP: awready = wready = 0; bvalid/bresp stable until bready; on bvalid&&bready edge bvalid <= 0, -> W_IDLE.
- Read FSM, states R_IDLE, R_RESP:
  - R_IDLE: arready = 1. On arvalid edge, rdata <= mem[idx] (or 0), rresp set, rvalid <= 1, -> R_RESP.
  - R_RESP: arready = 0; rdata/rresp/rvalid stable until rready; on handshake rvalid <= 0, rdata <= 0, -> R_IDLE.
- Read and write channels are independent. Same word written and read on the same edge: read returns pre-write data.
- err_count increments by 1 per SLVERR response issued, by 2 if read and write both issue SLVERR on the same edge. Saturates at 16'hFFFF.
- wstrb = 0 with a valid address: OKAY, memory unchanged.

## Timing
- All outputs driven from registers only; no combinational input-to-output path.
- Reset (async assert): awready = wready = arready = 0 while reset high. bvalid = rvalid = 0, bresp = rresp = 2'b00, rdata = 0, err_count = 0. FSMs go to IDLE, holds cleared, word 0 = RESET_WORD0. Other words retain contents.
- First cycle after reset deassert: awready = wready = arready = 1.
- Write latency: AW+W accepted on edge N -> bvalid high from N+1. Earliest next AW/W acceptance is the edge after the B handshake.
- Read latency: AR accepted on edge N -> rvalid high from N+1. Sustained throughput is one read per 2 cycles with rready tied high.
- Reset mid-transaction aborts it: held AW/W are discarded, and an in-flight B or R is dropped without a handshake.

## Structure
- Package axi4_lite_pkg: resp_t (OKAY=2'b00, SLVERR=2'b10), wr_state_t, rd_state_t.
- Sub-module axi4_lite_ram_array: DEPTH×DATA_WIDTH storage with per-byte write enable, one synchronous read port, async reset of word 0 only.
- Top level holds both FSMs, the address decode and err_count.

## Test plan
- Reset, then read 0x0 -> rdata 32'hDEADBEEF, OKAY, rvalid at N+1.
- AW 0x10 on cycle 2 and W 32'h12345678 (wstrb 4'hF) on cycle 5 -> bvalid at cycle 6, OKAY. Read 0x10 -> 32'h12345678.
- Write 32'hAABBCCDD with wstrb 4'b0101 to a word holding 32'h12345678 -> read returns 32'h12BB56DD.
- Write to 0x100 (DEPTH 64) -> SLVERR, memory unchanged. Read 0x100 -> rdata 0, SLVERR. err_count = 2.
- Hold bready = 0 for 10 cycles -> bvalid/bresp stable, awready = wready = 0. Likewise hold rready low -> rdata stable, arready = 0.
- Assert reset while rvalid = 1 and an AW is held -> rvalid = 0 immediately. After release, a W alone does not produce bvalid.
